// File: rtl/zoom_pkg.sv
// ============================================================================
// Module   : zoom_pkg
// Purpose  : Shared RGB565 lane layout and default sizes for the ZOOM path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package zoom_pkg;
    localparam int PIX_W = 16;
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int R_LSB = 11;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    localparam int FRAC_W_DEF = 4;
    localparam int OUT_W_DEF  = 1280;
    localparam int OUT_H_DEF  = 720;
endpackage

`default_nettype wire

// File: rtl/bilerp_lane.sv
// ============================================================================
// Module   : bilerp_lane
// Purpose  : One colour channel: horizontal blend, vertical blend, normalise.
//            ZOOM_ROUND_EN selects round-half-up instead of truncation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bilerp_lane #(
    parameter int CW     = 5,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     a11,
    input  logic [CW-1:0]     a12,
    input  logic [CW-1:0]     a21,
    input  logic [CW-1:0]     a22,
    input  logic [FRAC_W-1:0] fx,
    input  logic [FRAC_W-1:0] fy,
    output logic [CW-1:0]     res
);
    localparam int HW = CW + FRAC_W;
    localparam int VW = CW + 2 * FRAC_W;
    localparam logic [FRAC_W:0] c_unit = {1'b1, {FRAC_W{1'b0}}};
`ifdef ZOOM_ROUND_EN
    localparam logic [VW-1:0] c_rnd = {{(CW + 1){1'b0}}, 1'b1, {(2 * FRAC_W - 1){1'b0}}};
`endif

    logic [HW-1:0]     r_top_q, w_top_d;
    logic [HW-1:0]     r_bot_q, w_bot_d;
    logic [FRAC_W-1:0] r_fy_q,  w_fy_d;
    logic [VW-1:0]     r_v_q,   w_v_d;
    logic [CW-1:0]     r_res_q, w_res_d;
    logic [FRAC_W:0]   w_wx0, w_wy0;
    logic [VW-1:0]     w_norm;

    always_comb begin
        w_wx0   = c_unit - {1'b0, fx};
        w_top_d = HW'(a11) * HW'(w_wx0) + HW'(a12) * HW'(fx);
        w_bot_d = HW'(a21) * HW'(w_wx0) + HW'(a22) * HW'(fx);
        // fy is consumed one stage later, so it rides along with top/bot
        w_fy_d  = fy;
        w_wy0   = c_unit - {1'b0, r_fy_q};
        w_v_d   = VW'(r_top_q) * VW'(w_wy0) + VW'(r_bot_q) * VW'(r_fy_q);
`ifdef ZOOM_ROUND_EN
        w_norm  = r_v_q + c_rnd;
`else
        w_norm  = r_v_q;
`endif
        // The blend is a convex combination, so the top bits are always zero
        w_res_d = CW'(w_norm >> (2 * FRAC_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top_q <= '0;
            r_bot_q <= '0;
            r_fy_q  <= '0;
            r_v_q   <= '0;
            r_res_q <= '0;
        end else begin
            r_top_q <= w_top_d;
            r_bot_q <= w_bot_d;
            r_fy_q  <= w_fy_d;
            r_v_q   <= w_v_d;
            r_res_q <= w_res_d;
        end
    end

    assign res = r_res_q;
endmodule

`default_nettype wire

// File: rtl/zoom_bilinear_interp.sv
// ============================================================================
// Module   : zoom_bilinear_interp
// Purpose  : 2x2 RGB565 bilinear interpolator, 4-cycle pipe, frame-done pulse.
//            Build option ZOOM_ROUND_EN enables round-half-up normalisation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zoom_bilinear_interp
    import zoom_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int OUT_H  = OUT_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_vs,
    input  logic              din_vld,
    input  logic [15:0]       din1_1,
    input  logic [15:0]       din1_2,
    input  logic [15:0]       din2_1,
    input  logic [15:0]       din2_2,
    input  logic [FRAC_W-1:0] frac_x,
    input  logic [FRAC_W-1:0] frac_y,
    output logic              dout_vld,
    output logic [15:0]       dout,
    output logic              frame_done
);
    localparam int c_total = OUT_W * OUT_H;
    localparam int CNT_W   = $clog2(c_total);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(c_total - 1);

    logic [PIX_W-1:0]  r_p11_q, r_p12_q, r_p21_q, r_p22_q;
    logic [FRAC_W-1:0] r_fx_q, r_fy_q;
    logic [3:0]        r_vld_q, w_vld_d;
    logic              r_dout_vld_q, w_dout_vld_d;
    logic [PIX_W-1:0]  r_dout_q, w_dout_d;
    logic              r_frame_done_q, w_frame_done_d;
    logic [CNT_W-1:0]  r_cnt_q, w_cnt_d;
    logic [R_W-1:0]    w_res_r;
    logic [G_W-1:0]    w_res_g;
    logic [B_W-1:0]    w_res_b;
    logic [PIX_W-1:0]  w_pix;

    bilerp_lane #(.CW(R_W), .FRAC_W(FRAC_W)) u_lane_r (
        .clk(clk), .rst(rst),
        .a11(r_p11_q[R_LSB +: R_W]), .a12(r_p12_q[R_LSB +: R_W]),
        .a21(r_p21_q[R_LSB +: R_W]), .a22(r_p22_q[R_LSB +: R_W]),
        .fx(r_fx_q), .fy(r_fy_q), .res(w_res_r)
    );
    bilerp_lane #(.CW(G_W), .FRAC_W(FRAC_W)) u_lane_g (
        .clk(clk), .rst(rst),
        .a11(r_p11_q[G_LSB +: G_W]), .a12(r_p12_q[G_LSB +: G_W]),
        .a21(r_p21_q[G_LSB +: G_W]), .a22(r_p22_q[G_LSB +: G_W]),
        .fx(r_fx_q), .fy(r_fy_q), .res(w_res_g)
    );
    bilerp_lane #(.CW(B_W), .FRAC_W(FRAC_W)) u_lane_b (
        .clk(clk), .rst(rst),
        .a11(r_p11_q[B_LSB +: B_W]), .a12(r_p12_q[B_LSB +: B_W]),
        .a21(r_p21_q[B_LSB +: B_W]), .a22(r_p22_q[B_LSB +: B_W]),
        .fx(r_fx_q), .fy(r_fy_q), .res(w_res_b)
    );

    always_comb begin
        w_pix                 = '0;
        w_pix[R_LSB +: R_W]   = w_res_r;
        w_pix[G_LSB +: G_W]   = w_res_g;
        w_pix[B_LSB +: B_W]   = w_res_b;

        w_vld_d         = {r_vld_q[2:0], din_vld};
        w_dout_vld_d    = r_vld_q[3];
        w_dout_d        = r_vld_q[3] ? w_pix : r_dout_q;
        w_frame_done_d  = 1'b0;
        w_cnt_d         = r_cnt_q;

        // Flush takes priority over everything, including a last-pixel wrap
        if (vga_vs) begin
            w_vld_d      = '0;
            w_dout_vld_d = 1'b0;
            w_cnt_d      = '0;
        end else if (r_vld_q[3]) begin
            if (r_cnt_q == c_last) begin
                w_cnt_d        = '0;
                w_frame_done_d = 1'b1;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p11_q        <= '0;
            r_p12_q        <= '0;
            r_p21_q        <= '0;
            r_p22_q        <= '0;
            r_fx_q         <= '0;
            r_fy_q         <= '0;
            r_vld_q        <= '0;
            r_dout_vld_q   <= 1'b0;
            r_dout_q       <= '0;
            r_frame_done_q <= 1'b0;
            r_cnt_q        <= '0;
        end else begin
            r_p11_q        <= din1_1;
            r_p12_q        <= din1_2;
            r_p21_q        <= din2_1;
            r_p22_q        <= din2_2;
            r_fx_q         <= frac_x;
            r_fy_q         <= frac_y;
            r_vld_q        <= w_vld_d;
            r_dout_vld_q   <= w_dout_vld_d;
            r_dout_q       <= w_dout_d;
            r_frame_done_q <= w_frame_done_d;
            r_cnt_q        <= w_cnt_d;
        end
    end

    assign dout_vld   = r_dout_vld_q;
    assign dout       = r_dout_q;
    assign frame_done = r_frame_done_q;
endmodule

`default_nettype wire

// File: tb/tb_zoom_bilinear_interp.sv
// ============================================================================
// Module   : tb_zoom_bilinear_interp
// Purpose  : Directed self-checking bench for zoom_bilinear_interp (FRAC_W=4,
//            4x2 frame). Honours ZOOM_ROUND_EN for the rounding-sensitive vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_zoom_bilinear_interp;
    logic        clk = 1'b0;
    logic        rst;
    logic        vga_vs;
    logic        din_vld;
    logic [15:0] din1_1, din1_2, din2_1, din2_2;
    logic [3:0]  frac_x, frac_y;
    logic        dout_vld;
    logic [15:0] dout;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

`ifdef ZOOM_ROUND_EN
    localparam logic [15:0] HALF_EXP = 16'h8410;
`else
    localparam logic [15:0] HALF_EXP = 16'h7BEF;
`endif

    always #5 clk = ~clk;

    zoom_bilinear_interp #(.FRAC_W(4), .OUT_W(4), .OUT_H(2)) dut (
        .clk(clk), .rst(rst), .vga_vs(vga_vs), .din_vld(din_vld),
        .din1_1(din1_1), .din1_2(din1_2), .din2_1(din2_1), .din2_2(din2_2),
        .frac_x(frac_x), .frac_y(frac_y),
        .dout_vld(dout_vld), .dout(dout), .frame_done(frame_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input logic [3:0] x, input logic [3:0] y,
                         input logic v);
        din1_1 = a; din1_2 = b; din2_1 = c; din2_2 = d;
        frac_x = x; frac_y = y; din_vld = v;
    endtask

    // One sample accepted at edge N, result checked right after edge N+4
    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          input logic [3:0] x, input logic [3:0] y, input logic [15:0] exp);
        drive(a, b, c, d, x, y, 1'b1);
        tick;
        din_vld = 1'b0;
        repeat (4) tick;
        chk({tag, "_vld"}, {15'd0, dout_vld}, 16'd1);
        chk(tag, dout, exp);
    endtask

    initial begin
        logic e;
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; vga_vs = 1'b0;
        drive(16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0);
        repeat (2) tick;
        chk("rst_vld", {15'd0, dout_vld}, 16'd0);
        chk("rst_dout", dout, 16'h0000);
        chk("rst_fd", {15'd0, frame_done}, 16'd0);
        rst = 1'b0;
        tick;

        // Corner weights: exact passthrough of p11, one-cycle valid pulse
        drive(16'h1234, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1);
        tick;
        din_vld = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk("corner_vld", {15'd0, dout_vld}, {15'd0, (k == 4)});
            if (k == 4) chk("corner_dout", dout, 16'h1234);
        end

        single("half_x", 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 4'd8, 4'd0, HALF_EXP);
        single("half_y", 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 4'd0, 4'd8, HALF_EXP);
        single("p22_15", 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 4'd15, 4'd15, 16'hDEFB);
        single("p12_15", 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 4'd15, 4'd0, 16'hEF7D);

        // Full-scale back-to-back stream
        drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd15, 4'd15, 1'b1);
        for (int k = 0; k <= 24; k++) begin
            tick;
            if (k == 19) din_vld = 1'b0;
            e = (k >= 4 && k <= 23);
            chk("ovf_vld", {15'd0, dout_vld}, {15'd0, e});
            if (e) chk("ovf_dout", dout, 16'hFFFF);
        end

        rst = 1'b1;
        tick;
        rst = 1'b0;

        // Frame counter: 16 samples, pulses on output 8 and 16
        drive(16'd100, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k <= 21; k++) begin
            tick;
            din1_1 = 16'(100 + k + 1);
            if (k == 15) din_vld = 1'b0;
            e = (k >= 4 && k <= 19);
            chk("frm_vld", {15'd0, dout_vld}, {15'd0, e});
            chk("frm_fd", {15'd0, frame_done}, {15'd0, (k == 11 || k == 19)});
            if (e) chk("frm_dout", dout, 16'(100 + k - 4));
        end

        // Bubbles: valid pattern reproduced 4 cycles later (counter ends at 4)
        drive(16'd200, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, pat[0]);
        for (int k = 0; k <= 10; k++) begin
            tick;
            if (k < 5) begin
                din_vld = pat[k + 1];
                din1_1  = 16'(200 + k + 1);
            end else begin
                din_vld = 1'b0;
            end
            e = (k >= 4 && k <= 9) ? pat[k - 4] : 1'b0;
            chk("bub_vld", {15'd0, dout_vld}, {15'd0, e});
            if (e) chk("bub_dout", dout, 16'(200 + k - 4));
        end

        // Flush with three samples in flight; din_vld held high during flush
        drive(16'd300, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k <= 8; k++) begin
            tick;
            if (k == 2) vga_vs = 1'b1;
            if (k == 3) begin vga_vs = 1'b0; din_vld = 1'b0; end
            if (k >= 3) begin
                chk("fl_vld", {15'd0, dout_vld}, 16'd0);
                chk("fl_fd", {15'd0, frame_done}, 16'd0);
            end
        end

        // Counter must restart from 0: pulse on the 8th output only
        drive(16'd400, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k <= 13; k++) begin
            tick;
            if (k == 7) din_vld = 1'b0;
            chk("cnt_vld", {15'd0, dout_vld}, {15'd0, (k >= 4 && k <= 11)});
            chk("cnt_fd", {15'd0, frame_done}, {15'd0, (k == 11)});
        end

        // Asynchronous reset mid-stream
        drive(16'h0ABC, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1);
        repeat (6) tick;
        chk("ar_pre_vld", {15'd0, dout_vld}, 16'd1);
        chk("ar_pre_dout", dout, 16'h0ABC);
        #1 rst = 1'b1;
        #1;
        chk("ar_vld", {15'd0, dout_vld}, 16'd0);
        chk("ar_dout", dout, 16'h0000);
        tick;
        rst = 1'b0;
        din_vld = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("ar_post_vld", {15'd0, dout_vld}, 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
